four_12_12_st1_st_activation: RTL and testbench
===============================================

// Module: four_12_12_st1_st_activation
// PURPOSE
//  Output stage directly downstream of the stage-1 bias adder. Applies ReLU to each
//  registered float_24_8 sum and tags the last element of every VEC_LEN-element vector.
//  Buffers results in a small FIFO and presents them through a valid/ready interface
//  to the next layer.
//  The bias adder cannot stall, so the input side is push-only. Overflow is flagged,
//  never back-pressured.
// PARAMETERS
//  DEPTH       4   FIFO entries; power of two, >=2
//  VEC_LEN     12  elements per vector; out_last marks element VEC_LEN-1
//  LEAK_SHIFT  3   leaky slope 2^-LEAK_SHIFT; used only with ACT_LEAKY_EN
// PORTS
//  clk        in   1   clock; one clock domain
//  reset      in   1   asynchronous, active-high reset
//  in_valid   in   1   in_data is a new bias-adder result this cycle
//  in_data    in   32  float_24_8 {sgn, exp[7:0], man[22:0]}
//  out_valid  out  1   FIFO head valid
//  out_ready  in   1   consumer accepts the head this cycle
//  out_data   out  32  float_24_8 activated value
//  out_last   out  1   head is element VEC_LEN-1 of its vector
//  ovf        out  1   sticky: an input was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async assert): all of the following clear to 0 — out_valid, out_data,
//   out_last, ovf, act register, FIFO pointers/count, element counter.
//  Stage A (1 cycle): act_q <= f(in_data); act_v <= in_valid.
//   Latency: in_valid to out_valid is 2 cycles when the FIFO is empty.
//  f(x), ReLU:
//   - exp==0 (zero/denormal) -> 32'h0.
//   - sgn==1 -> 32'h0.
//   - otherwise x unchanged.
//  Push: act_v && !full, or act_v && full && pop in the same cycle.
//   Simultaneous push and pop on a full FIFO is legal; count is unchanged.
//  Drop: act_v && full && !pop. The entry is discarded, ovf <= 1 until reset, and
//   the element counter does NOT advance.
//  Element counter: idx 0..VEC_LEN-1, advances on each push.
//   A pushed entry stores last = (idx==VEC_LEN-1); idx then wraps to 0.
//  Pop: out_valid && out_ready. Head advances next cycle.
//   out_data/out_last are stable while out_valid && !out_ready.
//  Empty: out_valid=0 and out_data holds its last value. Pop on empty is ignored.
//  Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits.
//  Reset mid-vector: the partial vector is discarded and idx restarts at 0.
// CONFIGURATION
//  ACT_LEAKY_EN defined: negative x is scaled by 2^-LEAK_SHIFT instead of zeroed.
//   - sgn kept, man kept, exp -= LEAK_SHIFT.
//   - If exp <= LEAK_SHIFT, the result flushes to 32'h0.
//   - exp==0 still yields 0.
//  ACT_LEAKY_EN undefined: plain ReLU as above. LEAK_SHIFT is unused.
// STRUCTURE
//  float_24_8 typedef comes from the shared types package (types.v).
//  Add to that package: FLOAT_ZERO = 32'h0 and an exp-width constant.
//  One sub-module: four_12_12_act_fifo, a generic DEPTH x WIDTH synchronous FIFO.
//   - WIDTH = 33 (data + last).
//   - Ports: push, pop, din, dout, full, empty.
//   - Asynchronous active-high reset.
//  Top level holds: the activation function, stage-A register, element counter,
//  and ovf logic.
// TESTING
//  1. in 0x3F800000 (1.0), out_ready=1 -> 0x3F800000 with out_valid 2 cycles later.
//  2. in 0xC0000000 (-2.0) -> 0x00000000. With ACT_LEAKY_EN, LEAK_SHIFT=3:
//     0xBE800000 (-0.25).
//  3. Stream 24 positive values, out_ready=1 -> out_last high on outputs 12 and 24 only.
//  4. out_ready=0 with 5 consecutive inputs (DEPTH=4):
//     -> 4 buffered, 5th dropped, ovf=1.
//     -> Release ready: exactly 4 drained in order, ovf stays 1.
//  5. FIFO full, push and pop in the same cycle -> no drop, count stays 4,
//     ordering preserved.
//  6. Assert reset asynchronously mid-vector after 7 pushes:
//     -> out_valid=0 and ovf=0 immediately.
//     -> Next 12 inputs: last on the 12th.

Source files
------------

// File: rtl/four_12_12_st1_st_activation_pkg.sv
// rtl/four_12_12_st1_st_activation_pkg.sv - shared float_24_8 type and constants
package four_12_12_st1_st_activation_pkg;

    localparam int FLOAT_EXP_W = 8;
    localparam int FLOAT_MAN_W = 23;

    typedef struct packed {
        logic                   sgn;
        logic [FLOAT_EXP_W-1:0] exp;
        logic [FLOAT_MAN_W-1:0] man;
    } float_24_8;

    localparam logic [31:0] FLOAT_ZERO = 32'h0;

endpackage

// File: rtl/four_12_12_act_fifo.sv
// rtl/four_12_12_act_fifo.sv - generic DEPTH x WIDTH synchronous FIFO
module four_12_12_act_fifo
    import four_12_12_st1_st_activation_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] hold_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // When empty, present the most recently popped word so the output holds still.
    assign dout = empty ? hold_q : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold_q <= mem[rd_ptr];
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/four_12_12_st1_st_activation.sv
// rtl/four_12_12_st1_st_activation.sv - ReLU output stage with vector tagging and FIFO
// ACT_LEAKY_EN selects leaky ReLU (negatives scaled by 2^-LEAK_SHIFT) instead of zeroing.
module four_12_12_st1_st_activation
    import four_12_12_st1_st_activation_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int VEC_LEN    = 12,
    parameter int LEAK_SHIFT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        ovf
);

    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    float_24_8        in_f;
    logic [31:0]      act_d;
    logic [31:0]      act_q;
    logic             act_v;
    logic [IDX_W-1:0] idx;
    logic             last_in;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             drop;

    assign in_f = in_data;

`ifdef ACT_LEAKY_EN
    always_comb begin
        act_d = in_f;
        if (in_f.exp == '0) begin
            act_d = FLOAT_ZERO;
        end else if (in_f.sgn) begin
            // Exponent too small to scale without underflow: flush to zero.
            if (in_f.exp <= FLOAT_EXP_W'(LEAK_SHIFT)) begin
                act_d = FLOAT_ZERO;
            end else begin
                act_d = {in_f.sgn, in_f.exp - FLOAT_EXP_W'(LEAK_SHIFT), in_f.man};
            end
        end
    end
`else
    logic [7:0] unused_leak_shift;
    assign unused_leak_shift = 8'(LEAK_SHIFT);

    always_comb begin
        act_d = in_f;
        if (in_f.exp == '0 || in_f.sgn) begin
            act_d = FLOAT_ZERO;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_q <= '0;
            act_v <= 1'b0;
        end else begin
            act_q <= act_d;
            act_v <= in_valid;
        end
    end

    // Upstream cannot stall: a full FIFO drops unless a pop frees a slot this cycle.
    assign pop     = out_valid && out_ready;
    assign push    = act_v && (!full || pop);
    assign drop    = act_v && full && !pop;
    assign last_in = (idx == IDX_W'(VEC_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            ovf <= 1'b0;
        end else begin
            if (push) begin
                idx <= last_in ? '0 : idx + IDX_W'(1);
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    four_12_12_act_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({last_in, act_q}),
        .dout  ({out_last, out_data}),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_four_12_12_st1_st_activation.sv
// tb/tb_four_12_12_st1_st_activation.sv - directed bench for four_12_12_st1_st_activation
module tb_four_12_12_st1_st_activation;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        ovf;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] got_d[$];
    logic        got_l[$];

    typedef struct {
        logic [31:0] din;
        logic [31:0] dexp;
    } vec_t;

    vec_t vecs[10];

    four_12_12_st1_st_activation dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Drive n inputs base+i back to back while recording every handshake.
    task automatic stream(input int n, input logic [31:0] base, input int budget);
        got_d.delete();
        got_l.delete();
        for (int c = 0; c < budget; c++) begin
            in_valid = (c < n);
            in_data  = base + c;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h3F800000, 32'h3F800000};
        vecs[1] = '{32'h00000000, 32'h00000000};
        vecs[2] = '{32'h007FFFFF, 32'h00000000};
        vecs[3] = '{32'h7F7FFFFF, 32'h7F7FFFFF};
        vecs[4] = '{32'h00800000, 32'h00800000};
        vecs[5] = '{32'h80000001, 32'h00000000};
`ifdef ACT_LEAKY_EN
        vecs[6] = '{32'hC0000000, 32'hBE800000};
        vecs[7] = '{32'hBF800000, 32'hBE000000};
        vecs[8] = '{32'h81800000, 32'h00000000};
        vecs[9] = '{32'h82000000, 32'h80800000};
`else
        vecs[6] = '{32'hC0000000, 32'h00000000};
        vecs[7] = '{32'hBF800000, 32'h00000000};
        vecs[8] = '{32'h81800000, 32'h00000000};
        vecs[9] = '{32'h82000000, 32'h00000000};
`endif

        out_ready = 1'b0;
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Single values: 2-cycle latency, activation result, pop on ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 32'd0);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_data", i), out_data, vecs[i].dexp);
            chk($sformatf("v%0d_last", i), 32'(out_last), 32'd0);
            tick();
            chk($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d_hold", i), out_data, vecs[i].dexp);
        end

        // 24 streamed values: last on outputs 12 and 24 only.
        do_reset();
        out_ready = 1'b1;
        stream(24, 32'h41000000, 40);
        chk("t3_count", 32'(got_d.size()), 32'd24);
        for (int i = 0; i < got_d.size(); i++) begin
            chk($sformatf("t3_data%0d", i), got_d[i], 32'h41000000 + i);
            chk($sformatf("t3_last%0d", i), 32'(got_l[i]), 32'((i % 12) == 11));
        end

        // Five inputs into a stalled FIFO: fifth dropped, ovf sticky.
        do_reset();
        out_ready = 1'b0;
        stream(5, 32'h42000000, 8);
        chk("t4_ovf", 32'(ovf), 32'd1);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_head", out_data, 32'h42000000);
        tick();
        chk("t4_head_stable", out_data, 32'h42000000);
        out_ready = 1'b1;
        stream(0, 32'h0, 10);
        chk("t4_count", 32'(got_d.size()), 32'd4);
        for (int i = 0; i < got_d.size(); i++) begin
            chk($sformatf("t4_data%0d", i), got_d[i], 32'h42000000 + i);
        end
        chk("t4_ovf_sticky", 32'(ovf), 32'd1);

        // Full FIFO with push and pop on the same edge: nothing lost.
        do_reset();
        out_ready = 1'b0;
        stream(4, 32'h43000000, 6);
        in_valid = 1'b1;
        in_data  = 32'h43000004;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        stream(0, 32'h0, 10);
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_count", 32'(got_d.size()), 32'd5);
        for (int i = 0; i < got_d.size(); i++) begin
            chk($sformatf("t5_data%0d", i), got_d[i], 32'h43000000 + i);
        end

        // Asynchronous reset mid-vector.
        do_reset();
        out_ready = 1'b0;
        stream(7, 32'h44000000, 9);
        chk("t6_pre_ovf", 32'(ovf), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_ovf", 32'(ovf), 32'd0);
        chk("t6_async_data", out_data, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        stream(12, 32'h45000000, 20);
        chk("t6_count", 32'(got_d.size()), 32'd12);
        for (int i = 0; i < got_d.size(); i++) begin
            chk($sformatf("t6_last%0d", i), 32'(got_l[i]), 32'(i == 11));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
